// File: rtl/control_unit_pkg.sv
// control_unit_pkg
// Shared constants for the SPARC-V8 multicycle control unit: state
// encodings, instruction field codes, branch condition codes, ALU function
// codes, RAM transfer sizes and default trap types. It also holds helper
// functions used when decoding an instruction.
package control_unit_pkg;

  typedef logic [3:0] state_t;

  // FSM state encodings. These are plain constants so that older blocks
  // and debug tools can keep comparing the state port against numbers.
  localparam state_t S_RESET = 4'd0;
  localparam state_t S_F0    = 4'd1;
  localparam state_t S_F1    = 4'd2;
  localparam state_t S_F2    = 4'd3;
  localparam state_t S_DEC   = 4'd4;
  localparam state_t S_ALU   = 4'd5;
  localparam state_t S_MA    = 4'd6;
  localparam state_t S_LD0   = 4'd7;
  localparam state_t S_LD1   = 4'd8;
  localparam state_t S_LD2   = 4'd9;
  localparam state_t S_ST0   = 4'd10;
  localparam state_t S_ST1   = 4'd11;
  localparam state_t S_BR    = 4'd12;
  localparam state_t S_CALL  = 4'd13;
  localparam state_t S_UPD   = 4'd14;
  localparam state_t S_TRAP  = 4'd15;

  // Instruction format (IR[31:30]) and format-2 sub-opcodes (IR[24:22])
  localparam logic [1:0] OP_FMT2  = 2'b00;
  localparam logic [1:0] OP_CALL  = 2'b01;
  localparam logic [1:0] OP_ARITH = 2'b10;
  localparam logic [1:0] OP_MEM   = 2'b11;
  localparam logic [2:0] OP2_BICC  = 3'b010;
  localparam logic [2:0] OP2_SETHI = 3'b100;

  // Arithmetic/logic op3 codes. The cc variants are these plus 6'h10.
  localparam logic [5:0] OP3_ADD  = 6'h00;
  localparam logic [5:0] OP3_AND  = 6'h01;
  localparam logic [5:0] OP3_OR   = 6'h02;
  localparam logic [5:0] OP3_XOR  = 6'h03;
  localparam logic [5:0] OP3_SUB  = 6'h04;
  localparam logic [5:0] OP3_ANDN = 6'h05;
  localparam logic [5:0] OP3_ORN  = 6'h06;
  localparam logic [5:0] OP3_XNOR = 6'h07;
  localparam logic [5:0] OP3_ADDX = 6'h08;
  localparam logic [5:0] OP3_SUBX = 6'h0C;
  localparam logic [5:0] OP3_SLL  = 6'h25;
  localparam logic [5:0] OP3_SRL  = 6'h26;
  localparam logic [5:0] OP3_SRA  = 6'h27;

  // Bicc condition codes (IR[28:25])
  localparam logic [3:0] COND_BN   = 4'b0000;
  localparam logic [3:0] COND_BE   = 4'b0001;
  localparam logic [3:0] COND_BLE  = 4'b0010;
  localparam logic [3:0] COND_BL   = 4'b0011;
  localparam logic [3:0] COND_BLEU = 4'b0100;
  localparam logic [3:0] COND_BCS  = 4'b0101;
  localparam logic [3:0] COND_BNEG = 4'b0110;
  localparam logic [3:0] COND_BVS  = 4'b0111;
  localparam logic [3:0] COND_BA   = 4'b1000;
  localparam logic [3:0] COND_BNE  = 4'b1001;
  localparam logic [3:0] COND_BG   = 4'b1010;
  localparam logic [3:0] COND_BGE  = 4'b1011;
  localparam logic [3:0] COND_BGU  = 4'b1100;
  localparam logic [3:0] COND_BCC  = 4'b1101;
  localparam logic [3:0] COND_BPOS = 4'b1110;
  localparam logic [3:0] COND_BVC  = 4'b1111;

  // ALU function codes. Arithmetic instructions pass op3 straight through;
  // sethi uses a code that no supported op3 occupies.
  localparam logic [5:0] ALU_ADD   = 6'h00;
  localparam logic [5:0] ALU_SETHI = 6'h2F;

  // RAM transfer sizes
  localparam logic [1:0] SIZE_BYTE = 2'd0;
  localparam logic [1:0] SIZE_HALF = 2'd1;
  localparam logic [1:0] SIZE_WORD = 2'd2;

  // NPC source selects
  localparam logic [1:0] NPC_SEQ    = 2'd0;
  localparam logic [1:0] NPC_BRANCH = 2'd1;
  localparam logic [1:0] NPC_CALL   = 2'd2;

  // Defaults for the top-level parameters
  localparam int         MFC_TIMEOUT_DEF = 16;
  localparam logic [7:0] TT_MEM_DEF      = 8'h09;
  localparam logic [7:0] TT_ILLEGAL_DEF  = 8'h02;

  // op3[1:0] of a load/store picks the transfer size; 11 falls back to word.
  function automatic logic [1:0] mem_size(input logic [5:0] op3);
    case (op3[1:0])
      2'b01:   return SIZE_BYTE;
      2'b10:   return SIZE_HALF;
      default: return SIZE_WORD;
    endcase
  endfunction

  // True for op3 values the ALU implements (plain and cc forms plus shifts).
  function automatic logic alu_op3_ok(input logic [5:0] op3);
    case (op3 & 6'b101111)
      OP3_ADD, OP3_AND, OP3_OR, OP3_XOR, OP3_SUB, OP3_ANDN, OP3_ORN,
      OP3_XNOR, OP3_ADDX, OP3_SUBX: return !op3[5];
      OP3_SLL, OP3_SRL, OP3_SRA:    return !op3[4];
      default:                      return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/control_unit_icc_cond_eval.sv
// icc_cond_eval
// Combinational evaluation of the 16 SPARC Bicc conditions against the
// PSR integer condition codes.
//   cond[3:0]   in  : branch condition field IR[28:25]
//   n, z, v, c  in  : PSR icc flags
//   taken       out : 1 when the branch condition holds
module icc_cond_eval
  import control_unit_pkg::*;
(
  input  logic [3:0] cond,
  input  logic       n,
  input  logic       z,
  input  logic       v,
  input  logic       c,
  output logic       taken
);

  // Conditions 8..15 are the logical inverses of conditions 0..7, so only
  // the low half is evaluated and cond[3] flips the result.
  logic base;

  always_comb begin
    base = 1'b0;
    case (cond[2:0])
      COND_BN[2:0]:   base = 1'b0;
      COND_BE[2:0]:   base = z;
      COND_BLE[2:0]:  base = z | (n ^ v);
      COND_BL[2:0]:   base = n ^ v;
      COND_BLEU[2:0]: base = c | z;
      COND_BCS[2:0]:  base = c;
      COND_BNEG[2:0]: base = n;
      COND_BVS[2:0]:  base = v;
      default:        base = 1'b0;
    endcase
    taken = base ^ cond[3];
  end

endmodule

// File: rtl/control_unit.sv
// control_unit
// Multicycle microsequencer for the SPARC-V8 datapath. Walks each
// instruction through fetch / decode / execute / writeback, drives every
// register load strobe and mux select, handshakes with the RAM over MFC,
// resolves Bicc branches and raises a one-cycle trap on a memory timeout
// or an unsupported opcode.
//   Clk, Clr                 : clock (rising edge), async active-high reset
//   IR_in[31:0]              : current instruction register contents
//   MFC                      : memory function complete from the RAM
//   N, Z, V, C               : PSR icc flags
//   *_enable / *_Enable, RF_we : register load strobes
//   NPC_sel[1:0]             : 0=NPC+4, 1=branch target, 2=call target
//   MDR_Mux_S, MAR_sel       : MDR source (0=ALU,1=RAM), MAR source (0=PC,1=ALU)
//   RAM_enable, RAM_rw, RAM_size[1:0] : memory strobe, 1=read, 0/1/2=byte/half/word
//   alu_op[5:0], alu_b_imm   : ALU function and simm13 select for operand B
//   trap, tt[7:0]            : one-cycle trap pulse and its trap type
//   state[3:0]               : current FSM state for debug
module control_unit
  import control_unit_pkg::*;
#(
  parameter int         MFC_TIMEOUT = MFC_TIMEOUT_DEF,
  parameter logic [7:0] TT_MEM      = TT_MEM_DEF,
  parameter logic [7:0] TT_ILLEGAL  = TT_ILLEGAL_DEF
) (
  input  logic        Clk,
  input  logic        Clr,
  input  logic [31:0] IR_in,
  input  logic        MFC,
  input  logic        N,
  input  logic        Z,
  input  logic        V,
  input  logic        C,
  output logic        PC_enable,
  output logic        NPC_enable,
  output logic        IR_Enable,
  output logic        MAR_Enable,
  output logic        MDR_Enable,
  output logic        PSR_Enable,
  output logic        RF_we,
  output logic [1:0]  NPC_sel,
  output logic        MDR_Mux_S,
  output logic        MAR_sel,
  output logic        RAM_enable,
  output logic        RAM_rw,
  output logic [1:0]  RAM_size,
  output logic [5:0]  alu_op,
  output logic        alu_b_imm,
  output logic        trap,
  output logic [7:0]  tt,
  output logic [3:0]  state
);

  localparam int CNT_W = (MFC_TIMEOUT > 2) ? $clog2(MFC_TIMEOUT) : 1;
  localparam logic [CNT_W-1:0] CNT_LIMIT = CNT_W'(MFC_TIMEOUT - 1);

  state_t           state_q, state_next;
  logic [CNT_W-1:0] to_cnt;
  logic [1:0]       npc_sel_q;
  logic             br_annul;
  logic             annul_q;
  logic [7:0]       tt_q, trap_code;
  logic             taken, mem_wait, timed_out;

  logic [1:0] op;
  logic [2:0] op2;
  logic [5:0] op3;
  logic       unused_ir;

  assign op        = IR_in[31:30];
  assign op2       = IR_in[24:22];
  assign op3       = IR_in[24:19];
  assign unused_ir = ^{IR_in[18:14], IR_in[12:0]};

  icc_cond_eval u_cond (
    .cond  (IR_in[28:25]),
    .n     (N),
    .z     (Z),
    .v     (V),
    .c     (C),
    .taken (taken)
  );

  // The three RAM wait states share one timeout counter. MFC on the limit
  // cycle still wins over the timeout.
  assign mem_wait  = (state_q == S_F1) || (state_q == S_LD0) || (state_q == S_ST1);
  assign timed_out = mem_wait && !MFC && (to_cnt == CNT_LIMIT);

  always_comb begin
    state_next = state_q;
    trap_code  = TT_MEM;
    case (state_q)
      S_RESET: state_next = S_F0;
      S_F0:    state_next = S_F1;
      S_F1:    state_next = MFC ? S_F2 : (timed_out ? S_TRAP : S_F1);
      // An annulled delay-slot instruction is fetched but never executed.
      S_F2:    state_next = annul_q ? S_UPD : S_DEC;
      S_DEC: begin
        case (op)
          OP_FMT2: begin
            if (op2 == OP2_BICC)       state_next = S_BR;
            else if (op2 == OP2_SETHI) state_next = S_ALU;
            else begin
              state_next = S_TRAP;
              trap_code  = TT_ILLEGAL;
            end
          end
          OP_CALL:  state_next = S_CALL;
          OP_ARITH: begin
            if (alu_op3_ok(op3)) state_next = S_ALU;
            else begin
              state_next = S_TRAP;
              trap_code  = TT_ILLEGAL;
            end
          end
          default:  state_next = S_MA;
        endcase
      end
      S_ALU:   state_next = S_UPD;
      // op3[2] separates stores (st/stb/sth) from loads.
      S_MA:    state_next = op3[2] ? S_ST0 : S_LD0;
      S_LD0:   state_next = MFC ? S_LD1 : (timed_out ? S_TRAP : S_LD0);
      S_LD1:   state_next = S_LD2;
      S_LD2:   state_next = S_UPD;
      S_ST0:   state_next = S_ST1;
      S_ST1:   state_next = MFC ? S_UPD : (timed_out ? S_TRAP : S_ST1);
      S_BR:    state_next = S_UPD;
      S_CALL:  state_next = S_UPD;
      S_UPD:   state_next = S_F0;
      S_TRAP:  state_next = S_F0;
      default: state_next = S_RESET;
    endcase
  end

  // The branch decision made in BR/CALL is held for UPD, where PC and NPC
  // actually load. The annul request also travels through UPD so it only
  // affects the next fetched instruction.
  always_ff @(posedge Clk or posedge Clr) begin
    if (Clr) begin
      state_q   <= S_RESET;
      to_cnt    <= '0;
      npc_sel_q <= NPC_SEQ;
      br_annul  <= 1'b0;
      annul_q   <= 1'b0;
      tt_q      <= 8'h00;
    end else begin
      state_q <= state_next;
      tt_q    <= (state_next == S_TRAP) ? trap_code : 8'h00;

      if (mem_wait && !MFC && !timed_out) to_cnt <= to_cnt + 1'b1;
      else                                to_cnt <= '0;

      case (state_q)
        S_BR: begin
          npc_sel_q <= taken ? NPC_BRANCH : NPC_SEQ;
          br_annul  <= IR_in[29] && (!taken || (IR_in[28:25] == COND_BA));
        end
        S_CALL: npc_sel_q <= NPC_CALL;
        S_UPD: begin
          npc_sel_q <= NPC_SEQ;
          annul_q   <= br_annul;
          br_annul  <= 1'b0;
        end
        S_F2:   annul_q <= 1'b0;
        S_TRAP: begin
          npc_sel_q <= NPC_SEQ;
          annul_q   <= 1'b0;
          br_annul  <= 1'b0;
        end
        default: ;
      endcase
    end
  end

  // Outputs are a pure function of the current state so an async Clr
  // drops RAM_enable in the same cycle.
  always_comb begin
    PC_enable  = 1'b0;
    NPC_enable = 1'b0;
    IR_Enable  = 1'b0;
    MAR_Enable = 1'b0;
    MDR_Enable = 1'b0;
    PSR_Enable = 1'b0;
    RF_we      = 1'b0;
    NPC_sel    = NPC_SEQ;
    MDR_Mux_S  = 1'b0;
    MAR_sel    = 1'b0;
    RAM_enable = 1'b0;
    RAM_rw     = 1'b1;
    RAM_size   = SIZE_WORD;
    alu_op     = ALU_ADD;
    alu_b_imm  = 1'b0;
    case (state_q)
      S_F0:  MAR_Enable = 1'b1;
      S_F1:  RAM_enable = 1'b1;
      S_F2:  IR_Enable  = 1'b1;
      S_ALU: begin
        alu_op     = (op == OP_FMT2) ? ALU_SETHI : op3;
        alu_b_imm  = IR_in[13];
        RF_we      = 1'b1;
        PSR_Enable = (op == OP_ARITH) && op3[4];
      end
      S_MA: begin
        alu_b_imm  = IR_in[13];
        MAR_sel    = 1'b1;
        MAR_Enable = 1'b1;
      end
      S_LD0: begin
        RAM_enable = 1'b1;
        RAM_size   = mem_size(op3);
      end
      S_LD1: begin
        MDR_Mux_S  = 1'b1;
        MDR_Enable = 1'b1;
      end
      S_LD2: RF_we = 1'b1;
      S_ST0: MDR_Enable = 1'b1;
      S_ST1: begin
        RAM_enable = 1'b1;
        RAM_rw     = 1'b0;
        RAM_size   = mem_size(op3);
      end
      S_BR:   NPC_sel = taken ? NPC_BRANCH : NPC_SEQ;
      S_CALL: begin
        RF_we   = 1'b1;
        NPC_sel = NPC_CALL;
      end
      S_UPD: begin
        PC_enable  = 1'b1;
        NPC_enable = 1'b1;
        NPC_sel    = npc_sel_q;
      end
      default: ;
    endcase
  end

  assign trap  = (state_q == S_TRAP);
  assign tt    = tt_q;
  assign state = state_q;

endmodule

// File: tb/tb_control_unit.sv
// tb_control_unit
// Directed bench for control_unit: reset behaviour, ALU, branch (taken,
// untaken, annulled), call, load with delayed MFC, store timeout and
// on-limit MFC, and illegal opcode trapping.
module tb_control_unit;
  import control_unit_pkg::*;

  logic        Clk, Clr;
  logic [31:0] IR_in;
  logic        MFC, N, Z, V, C;
  logic        PC_enable, NPC_enable, IR_Enable, MAR_Enable, MDR_Enable;
  logic        PSR_Enable, RF_we, MDR_Mux_S, MAR_sel, RAM_enable, RAM_rw;
  logic        alu_b_imm, trap;
  logic [1:0]  NPC_sel, RAM_size;
  logic [5:0]  alu_op;
  logic [7:0]  tt;
  logic [3:0]  state;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  int start_cyc;
  int ram_cycles;

  localparam logic [31:0] IR_ADD   = 32'h86004002;
  localparam logic [31:0] IR_ADDCC = 32'h86804002;
  localparam logic [31:0] IR_BNE   = 32'h12800004;
  localparam logic [31:0] IR_BNE_A = 32'h32800004;
  localparam logic [31:0] IR_CALL  = 32'h40000010;
  localparam logic [31:0] IR_LD    = 32'hC2006008;
  localparam logic [31:0] IR_ST    = 32'hC220A004;
  localparam logic [31:0] IR_ILL   = 32'h81F80000;

  control_unit dut (
    .Clk        (Clk),
    .Clr        (Clr),
    .IR_in      (IR_in),
    .MFC        (MFC),
    .N          (N),
    .Z          (Z),
    .V          (V),
    .C          (C),
    .PC_enable  (PC_enable),
    .NPC_enable (NPC_enable),
    .IR_Enable  (IR_Enable),
    .MAR_Enable (MAR_Enable),
    .MDR_Enable (MDR_Enable),
    .PSR_Enable (PSR_Enable),
    .RF_we      (RF_we),
    .NPC_sel    (NPC_sel),
    .MDR_Mux_S  (MDR_Mux_S),
    .MAR_sel    (MAR_sel),
    .RAM_enable (RAM_enable),
    .RAM_rw     (RAM_rw),
    .RAM_size   (RAM_size),
    .alu_op     (alu_op),
    .alu_b_imm  (alu_b_imm),
    .trap       (trap),
    .tt         (tt),
    .state      (state)
  );

  // 10 ns clock
  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  // Free-running cycle count used for latency checks
  always @(posedge Clk) cyc <= cyc + 1;

  // Hard stop in case the sequence gets stuck
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic applyStimulus(input logic [31:0] ir, input logic mfc,
                               input logic n, input logic z,
                               input logic v, input logic c);
    IR_in = ir;
    MFC   = mfc;
    N     = n;
    Z     = z;
    V     = v;
    C     = c;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    total++;
    assert (observed === expected)
      else begin
        bad++;
        $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, observed, expected);
      end
  endtask

  task automatic step();
    @(posedge Clk);
    #1;
  endtask

  // Starts in an F0 cycle, answers the fetch with MFC in the first wait
  // cycle and returns in F2.
  task automatic doFetch(input logic [31:0] ir, input logic z);
    applyStimulus(ir, 1'b1, 1'b0, z, 1'b0, 1'b0);
    step();
    checkOutput("fetch_f1_state", 32'(state), 32'(S_F1));
    checkOutput("fetch_f1_ram_en", 32'(RAM_enable), 32'd1);
    step();
    checkOutput("fetch_f2_ir_en", 32'(IR_Enable), 32'd1);
    MFC = 1'b0;
  endtask

  initial begin
    Clr = 1'b1;
    applyStimulus(32'h0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    #1;
    checkOutput("reset_state", 32'(state), 32'(S_RESET));
    checkOutput("reset_ram_en", 32'(RAM_enable), 32'd0);
    checkOutput("reset_ram_rw", 32'(RAM_rw), 32'd1);
    checkOutput("reset_ram_size", 32'(RAM_size), 32'd2);
    checkOutput("reset_tt", 32'(tt), 32'd0);
    checkOutput("reset_npc_sel", 32'(NPC_sel), 32'd0);
    step();
    step();
    Clr = 1'b0;
    step();
    checkOutput("rel_f0_state", 32'(state), 32'(S_F0));

    // Clr in the middle of a fetch wait
    step();
    checkOutput("mid_f1_ram_en", 32'(RAM_enable), 32'd1);
    Clr = 1'b1;
    #1;
    checkOutput("clr_same_cycle_state", 32'(state), 32'(S_RESET));
    checkOutput("clr_same_cycle_ram_en", 32'(RAM_enable), 32'd0);
    step();
    Clr = 1'b0;
    step();
    checkOutput("clr_rel_f0", 32'(state), 32'(S_F0));
    checkOutput("clr_rel_mar_en", 32'(MAR_Enable), 32'd1);

    // add %g1,%g2,%g3: six cycles F0..UPD
    start_cyc = cyc;
    doFetch(IR_ADD, 1'b0);
    step();
    checkOutput("add_dec", 32'(state), 32'(S_DEC));
    step();
    checkOutput("add_alu_state", 32'(state), 32'(S_ALU));
    checkOutput("add_rf_we", 32'(RF_we), 32'd1);
    checkOutput("add_psr_en", 32'(PSR_Enable), 32'd0);
    step();
    checkOutput("add_upd_pc_en", 32'(PC_enable), 32'd1);
    checkOutput("add_upd_npc_en", 32'(NPC_enable), 32'd1);
    checkOutput("add_upd_npc_sel", 32'(NPC_sel), 32'd0);
    step();
    checkOutput("add_back_f0", 32'(state), 32'(S_F0));
    checkOutput("add_latency", 32'(cyc - start_cyc), 32'd6);

    // addcc loads the PSR
    doFetch(IR_ADDCC, 1'b0);
    step();
    step();
    checkOutput("addcc_alu_op", 32'(alu_op), 32'h10);
    checkOutput("addcc_psr_en", 32'(PSR_Enable), 32'd1);
    step();
    step();

    // bne with Z=0 is taken
    doFetch(IR_BNE, 1'b0);
    step();
    step();
    checkOutput("bne_taken_br_state", 32'(state), 32'(S_BR));
    checkOutput("bne_taken_br_sel", 32'(NPC_sel), 32'd1);
    step();
    checkOutput("bne_taken_upd_sel", 32'(NPC_sel), 32'd1);
    step();

    // bne with Z=1 falls through
    doFetch(IR_BNE, 1'b1);
    step();
    step();
    step();
    checkOutput("bne_untaken_upd_state", 32'(state), 32'(S_UPD));
    checkOutput("bne_untaken_upd_sel", 32'(NPC_sel), 32'd0);
    step();

    // bne,a with Z=1: untaken, so the delay slot is annulled
    doFetch(IR_BNE_A, 1'b1);
    step();
    step();
    step();
    checkOutput("bnea_upd_sel", 32'(NPC_sel), 32'd0);
    step();
    doFetch(IR_ADD, 1'b1);
    step();
    checkOutput("annul_skip_dec", 32'(state), 32'(S_UPD));
    checkOutput("annul_upd_sel", 32'(NPC_sel), 32'd0);
    checkOutput("annul_no_rf_we", 32'(RF_we), 32'd0);
    step();

    // call writes r15 and selects the call target
    doFetch(IR_CALL, 1'b0);
    step();
    step();
    checkOutput("call_state", 32'(state), 32'(S_CALL));
    checkOutput("call_rf_we", 32'(RF_we), 32'd1);
    step();
    checkOutput("call_upd_sel", 32'(NPC_sel), 32'd2);
    step();

    // ld [%g1+8],%g1 with MFC arriving on the fourth wait cycle
    doFetch(IR_LD, 1'b0);
    step();
    checkOutput("ld_dec", 32'(state), 32'(S_DEC));
    step();
    checkOutput("ld_ma_mar_sel", 32'(MAR_sel), 32'd1);
    checkOutput("ld_ma_mar_en", 32'(MAR_Enable), 32'd1);
    checkOutput("ld_ma_ram_en", 32'(RAM_enable), 32'd0);
    ram_cycles = 0;
    for (int i = 0; i < 4; i++) begin
      step();
      if (RAM_enable === 1'b1 && state === S_LD0) ram_cycles++;
      if (i == 3) MFC = 1'b1;
    end
    checkOutput("ld_ram_cycles", 32'(ram_cycles), 32'd4);
    checkOutput("ld_ram_size", 32'(RAM_size), 32'd2);
    step();
    MFC = 1'b0;
    checkOutput("ld1_state", 32'(state), 32'(S_LD1));
    checkOutput("ld1_mdr_mux", 32'(MDR_Mux_S), 32'd1);
    checkOutput("ld1_mdr_en", 32'(MDR_Enable), 32'd1);
    step();
    checkOutput("ld2_rf_we", 32'(RF_we), 32'd1);
    step();
    checkOutput("ld_upd", 32'(state), 32'(S_UPD));
    step();

    // st with no MFC: 16 write cycles, then a memory trap
    doFetch(IR_ST, 1'b0);
    step();
    step();
    step();
    checkOutput("st0_state", 32'(state), 32'(S_ST0));
    checkOutput("st0_mdr_en", 32'(MDR_Enable), 32'd1);
    checkOutput("st0_mdr_mux", 32'(MDR_Mux_S), 32'd0);
    ram_cycles = 0;
    for (int i = 0; i < 16; i++) begin
      step();
      if (RAM_enable === 1'b1 && RAM_rw === 1'b0 && state === S_ST1) ram_cycles++;
    end
    checkOutput("st_timeout_ram_cycles", 32'(ram_cycles), 32'd16);
    step();
    checkOutput("st_timeout_trap", 32'(trap), 32'd1);
    checkOutput("st_timeout_tt", 32'(tt), 32'h09);
    checkOutput("st_timeout_ram_off", 32'(RAM_enable), 32'd0);
    step();
    checkOutput("st_timeout_f0", 32'(state), 32'(S_F0));
    checkOutput("st_timeout_trap_gone", 32'(trap), 32'd0);

    // st with MFC exactly on the limit cycle completes normally
    doFetch(IR_ST, 1'b0);
    step();
    step();
    step();
    for (int i = 0; i < 16; i++) begin
      step();
      if (i == 15) MFC = 1'b1;
    end
    step();
    MFC = 1'b0;
    checkOutput("st_limit_upd", 32'(state), 32'(S_UPD));
    checkOutput("st_limit_no_trap", 32'(trap), 32'd0);
    step();

    // op=10 with op3=3F traps as an illegal opcode
    doFetch(IR_ILL, 1'b0);
    step();
    step();
    checkOutput("ill_trap", 32'(trap), 32'd1);
    checkOutput("ill_tt", 32'(tt), 32'h02);
    checkOutput("ill_no_rf_we", 32'(RF_we), 32'd0);
    checkOutput("ill_no_psr", 32'(PSR_Enable), 32'd0);
    step();
    checkOutput("ill_f0", 32'(state), 32'(S_F0));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
